// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready
// handshake and presents {pc, inst} or a zero bubble to IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        inst_valid
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] target;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;

  logic st_idle, st_req, st_hold, st_drain;

  assign st_idle  = (state == IDLE);
  assign st_req   = (state == REQ);
  assign st_hold  = (state == HOLD);
  assign st_drain = (state == DRAIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= PC_RESET;
      target    <= '0;
      hold_pc   <= '0;
      hold_inst <= '0;
    end else begin
      unique case (1'b1)
        st_idle: state <= REQ;
        st_req: begin
          if (imem_ready && !branch_taken) begin
            hold_inst <= imem_rdata;
            hold_pc   <= pc + PC_STEP;
            state     <= HOLD;
          end else if (imem_ready) begin
            pc <= branch_addr;
          end else if (branch_taken) begin
            target <= branch_addr;
            state  <= DRAIN;
          end
        end
        st_hold: begin
          if (branch_taken) begin
            pc    <= branch_addr;
            state <= REQ;
          end else if (!freeze) begin
            pc    <= pc + PC_STEP;
            state <= REQ;
          end
        end
        st_drain: begin
          // the outstanding request keeps its address; only the
          // post-drain destination tracks the newest branch
          if (branch_taken) target <= branch_addr;
          if (imem_ready) begin
            pc    <= branch_taken ? branch_addr : target;
            state <= REQ;
          end
        end
      endcase
    end
  end

  assign imem_req   = st_req | st_drain;
  assign imem_addr  = pc;
  assign inst_valid = st_hold;
  assign pc_out     = st_hold ? hold_pc : '0;
  assign inst_out   = st_hold ? hold_inst : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an expected-presentation
// scoreboard; a second instance exercises PC wrap-around.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_ready;

  logic        req, w_req;
  logic [31:0] addr, w_addr;
  logic [31:0] rdata, w_rdata;
  logic [31:0] pc_out, w_pc_out;
  logic [31:0] inst_out, w_inst_out;
  logic        valid, w_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];

  assign rdata   = addr ^ 32'hA5A5_0000;
  assign w_rdata = w_addr ^ 32'hA5A5_0000;

  if_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (req),
    .imem_addr    (addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (rdata),
    .pc_out       (pc_out),
    .inst_out     (inst_out),
    .inst_valid   (valid)
  );

  if_fetch_unit #(.PC_RESET(32'hFFFF_FFFC)) u_wrap (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (w_req),
    .imem_addr    (w_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (w_rdata),
    .pc_out       (w_pc_out),
    .inst_out     (w_inst_out),
    .inst_valid   (w_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.pc   = a + 32'd4;
    e.inst = a ^ 32'hA5A5_0000;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
      chk({tag, "_pc"}, pc_out, e.pc);
      chk({tag, "_inst"}, inst_out, e.inst);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic bubble(input string tag);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    chk({tag, "_pc"}, pc_out, 32'd0);
    chk({tag, "_inst"}, inst_out, 32'd0);
  endtask

  initial begin
    rst          = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = '0;
    imem_ready   = 1'b1;

    tick;
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    bubble("rst");
    chk("rst_waddr", w_addr, 32'hFFFF_FFFC);

    rst = 1'b1;
    tick;
    chk("f0_req", {31'd0, req}, 32'd1);
    chk("f0_addr", addr, 32'd0);
    chk("w0_addr", w_addr, 32'hFFFF_FFFC);
    push(32'd0);
    tick;
    pop_chk("p0");
    chk("p0_req", {31'd0, req}, 32'd0);
    chk("w0_pc", w_pc_out, 32'd0);
    chk("w0_inst", w_inst_out, 32'h5A5A_FFFC);
    tick;
    chk("f1_addr", addr, 32'd4);
    chk("w1_addr", w_addr, 32'd0);
    push(32'd4);
    tick;
    pop_chk("p1");
    tick;
    chk("f2_addr", addr, 32'd8);
    push(32'd8);
    freeze = 1'b1;
    tick;
    pop_chk("p2");
    chk("p2_req", {31'd0, req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("frz_valid", {31'd0, valid}, 32'd1);
      chk("frz_pc", pc_out, 32'd12);
      chk("frz_inst", inst_out, 32'hA5A5_0008);
      chk("frz_req", {31'd0, req}, 32'd0);
      if (i == 2) freeze = 1'b0;
    end

    tick;
    chk("f3_req", {31'd0, req}, 32'd1);
    chk("f3_addr", addr, 32'd12);
    push(32'd12);
    tick;
    pop_chk("p3");
    freeze       = 1'b1;
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    tick;
    bubble("hbr");
    chk("hbr_req", {31'd0, req}, 32'd1);
    chk("hbr_addr", addr, 32'h100);
    freeze      = 1'b0;
    branch_addr = 32'd16;
    tick;
    chk("rbr_addr", addr, 32'd16);
    bubble("rbr");
    imem_ready  = 1'b0;
    branch_addr = 32'h200;
    tick;
    chk("dr1_addr", addr, 32'd16);
    chk("dr1_req", {31'd0, req}, 32'd1);
    bubble("dr1");
    branch_taken = 1'b0;
    tick;
    chk("dr2_addr", addr, 32'd16);
    tick;
    chk("dr3_addr", addr, 32'd16);
    imem_ready = 1'b1;
    tick;
    chk("dr_new_addr", addr, 32'h200);
    chk("dr_new_req", {31'd0, req}, 32'd1);
    bubble("dr_new");

    imem_ready   = 1'b0;
    branch_taken = 1'b1;
    branch_addr  = 32'h300;
    tick;
    chk("db1_addr", addr, 32'h200);
    branch_addr = 32'h400;
    tick;
    chk("db2_addr", addr, 32'h200);
    branch_taken = 1'b0;
    imem_ready   = 1'b1;
    tick;
    chk("db_new_addr", addr, 32'h400);
    push(32'h400);
    tick;
    pop_chk("p4");
    tick;
    chk("f5_addr", addr, 32'h404);
    imem_ready = 1'b0;

    #2 rst = 1'b0;
    #1;
    chk("arst_req", {31'd0, req}, 32'd0);
    chk("arst_addr", addr, 32'd0);
    chk("arst_valid", {31'd0, valid}, 32'd0);
    chk("arst_waddr", w_addr, 32'hFFFF_FFFC);
    tick;
    rst        = 1'b1;
    imem_ready = 1'b1;
    tick;
    chk("rs_req", {31'd0, req}, 32'd1);
    chk("rs_addr", addr, 32'd0);
    chk("rs_waddr", w_addr, 32'hFFFF_FFFC);
    push(32'd0);
    tick;
    pop_chk("p5");

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_left observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
